// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and the M-extension sequencer
interface muldiv_if #(parameter int XLEN = 32);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master(output start, flush, funct3, op_a, op_b, input busy, done, result);
    modport slave(input start, flush, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide with sign fix-up and a one-cycle done pulse
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input logic      clk,
    input logic      rst_n,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    state_t            state;
    logic [2:0]        f3;
    logic              a_neg;
    logic              b_neg;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opd;
    logic [CNT_W-1:0]  cnt;
    logic              done_q;
    logic [XLEN-1:0]   res_q;
    logic              a_sgn;
    logic              b_sgn;
    logic              div0;
    logic              ovf;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   spec_res;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic [XLEN-1:0]   fix_res;
    // accept-time decode, one shift-add / restoring step, and the final sign fix-up selection
    always_comb begin
        a_sgn     = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
        b_sgn     = bus.funct3 inside {3'b001, 3'b100, 3'b110};
        a_mag     = (a_sgn && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
        b_mag     = (b_sgn && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
        div0      = bus.funct3[2] && bus.op_b == '0;
        ovf       = bus.funct3[2] && !bus.funct3[0] && bus.op_a == INT_MIN && bus.op_b == '1;
        spec_res  = div0 ? (bus.funct3[1] ? bus.op_a : '1) : (bus.funct3[1] ? '0 : INT_MIN);
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
        div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opd};
        acc_next  = f3[2] ? (div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                             : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                          : {mul_sum, acc[XLEN-1:1]};
        prod_fix  = (a_neg ^ b_neg) ? -acc : acc;
        q_fix     = (a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r_fix     = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_res   = f3[2] ? (f3[1] ? r_fix : q_fix)
                          : (f3 == 3'b000 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
    end
    // sequencer FSM with registered done pulse and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            f3     <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            acc    <= '0;
            opd    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start && !bus.flush) begin
                    f3    <= bus.funct3;
                    a_neg <= a_sgn && bus.op_a[XLEN-1];
                    b_neg <= b_sgn && bus.op_b[XLEN-1];
                    cnt   <= '0;
                    if (div0 || ovf) begin
                        res_q  <= spec_res;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        acc   <= {{XLEN{1'b0}}, bus.funct3[2] ? a_mag : b_mag};
                        opd   <= bus.funct3[2] ? b_mag : a_mag;
                        state <= CALC;
                    end
                end
                CALC: if (bus.flush) state <= IDLE;
                else begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) state <= FIX;
                end
                FIX: if (bus.flush) state <= IDLE;
                else begin
                    res_q  <= fix_res;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy   = state != IDLE;
    assign bus.done   = done_q;
    assign bus.result = res_q;
endmodule
